seven_seg_scoreboard: RTL and testbench

Display-side consumer of the game's 5-bit countdown value and 7-bit score. It converts both to decimal and time-multiplexes them onto the Basys 3 4-digit, active-low seven-segment display. Timer digits sit on the left, score digits on the right. When the countdown reaches 0, the timer digits blink to signal game over. It sits between the timer/score logic and the board pins.

---
 rtl/seven_seg_scoreboard.sv | 214 +++++++++++++++++++++
 tb/tb_seven_seg_scoreboard.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scoreboard.sv
// Drives the Basys 3 4-digit active-low seven-segment display with the game countdown (left two digits)
// and the clamped score (right two digits), one digit per prescaler tick, blinking the timer at zero.
module seven_seg_scoreboard #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 62
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] count,
    input  logic [6:0] score,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int PS_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(REFRESH_DIV - 1);
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

    localparam logic [1:0] DIG_S_ONES = 2'd0;
    localparam logic [1:0] DIG_S_TENS = 2'd1;
    localparam logic [1:0] DIG_T_ONES = 2'd2;
    localparam logic [1:0] DIG_T_TENS = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SCORE_MAX = 7'd99;

    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] dec_tens(input logic [6:0] value);
        return 4'(value / 7'd10);
    endfunction

    function automatic logic [3:0] dec_ones(input logic [6:0] value);
        return 4'(value % 7'd10);
    endfunction

    logic [PS_W-1:0] prescaler_q, prescaler_d;
    logic [1:0]      index_q, index_d;
    logic [4:0]      count_sh_q, count_sh_d;
    logic [6:0]      score_sh_q, score_sh_d;
    logic            blink_sh_q, blink_sh_d;
    logic [FR_W-1:0] frame_q, frame_d;
    logic            blink_off_q, blink_off_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic            dp_q, dp_d;

    logic            tick_s;
    logic            capture_s;
    logic [6:0]      score_clamp_s;
    logic [3:0]      t_tens_s, t_ones_s, s_tens_s, s_ones_s;
    logic            timer_blank_s;
    logic [6:0]      digit_seg_s;
    logic [3:0]      digit_an_s;
    logic            digit_dp_s;

    // Prescaler, digit index and frame capture timing.
    always_comb begin
        tick_s    = (prescaler_q == PS_LAST);
        capture_s = tick_s && (index_q == DIG_T_TENS);
        if (tick_s) begin
            prescaler_d = '0;
            index_d     = index_q + 2'd1;
        end else begin
            prescaler_d = prescaler_q + PS_W'(1);
            index_d     = index_q;
        end
    end

    // Snapshot registers and blink phase; the blink phase seen by a frame is the one in force before its capture.
    always_comb begin
        count_sh_d  = count_sh_q;
        score_sh_d  = score_sh_q;
        blink_sh_d  = blink_sh_q;
        frame_d     = frame_q;
        blink_off_d = blink_off_q;
        if (capture_s) begin
            count_sh_d = count;
            score_sh_d = score;
            blink_sh_d = blink_off_q;
            if (frame_q == FR_LAST) begin
                frame_d     = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                frame_d     = frame_q + FR_W'(1);
                blink_off_d = blink_off_q;
            end
        end else begin
            count_sh_d = count_sh_q;
        end
    end

    // Decimal conversion of the snapshot that the next displayed digit belongs to.
    always_comb begin
        if (score_sh_d > SCORE_MAX) begin
            score_clamp_s = SCORE_MAX;
        end else begin
            score_clamp_s = score_sh_d;
        end
        t_tens_s      = dec_tens({2'b00, count_sh_d});
        t_ones_s      = dec_ones({2'b00, count_sh_d});
        s_tens_s      = dec_tens(score_clamp_s);
        s_ones_s      = dec_ones(score_clamp_s);
        timer_blank_s = (count_sh_d == 5'd0) && blink_sh_d;
    end

    // Digit multiplexer: anode, segments and separator for the selected position.
    always_comb begin
        digit_seg_s = SEG_BLANK;
        digit_an_s  = 4'b1111;
        digit_dp_s  = 1'b1;
        case (index_d)
            DIG_T_TENS: begin
                digit_an_s = 4'b0111;
                if (timer_blank_s || (t_tens_s == 4'd0)) begin
                    digit_seg_s = SEG_BLANK;
                end else begin
                    digit_seg_s = seg_code(t_tens_s);
                end
            end
            DIG_T_ONES: begin
                digit_an_s = 4'b1011;
                if (timer_blank_s) begin
                    digit_seg_s = SEG_BLANK;
                    digit_dp_s  = 1'b1;
                end else begin
                    digit_seg_s = seg_code(t_ones_s);
                    digit_dp_s  = 1'b0;
                end
            end
            DIG_S_TENS: begin
                digit_an_s = 4'b1101;
                if (s_tens_s == 4'd0) begin
                    digit_seg_s = SEG_BLANK;
                end else begin
                    digit_seg_s = seg_code(s_tens_s);
                end
            end
            DIG_S_ONES: begin
                digit_an_s  = 4'b1110;
                digit_seg_s = seg_code(s_ones_s);
            end
            default: begin
                digit_seg_s = SEG_BLANK;
                digit_an_s  = 4'b1111;
                digit_dp_s  = 1'b1;
            end
        endcase
    end

    // Output registers only change on a digit step.
    always_comb begin
        if (tick_s) begin
            seg_d = digit_seg_s;
            an_d  = digit_an_s;
            dp_d  = digit_dp_s;
        end else begin
            seg_d = seg_q;
            an_d  = an_q;
            dp_d  = dp_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q <= '0;
            index_q     <= DIG_T_TENS;
            count_sh_q  <= 5'd0;
            score_sh_q  <= 7'd0;
            blink_sh_q  <= 1'b0;
            frame_q     <= '0;
            blink_off_q <= 1'b0;
            seg_q       <= SEG_BLANK;
            an_q        <= 4'b1111;
            dp_q        <= 1'b1;
        end else begin
            prescaler_q <= prescaler_d;
            index_q     <= index_d;
            count_sh_q  <= count_sh_d;
            score_sh_q  <= score_sh_d;
            blink_sh_q  <= blink_sh_d;
            frame_q     <= frame_d;
            blink_off_q <= blink_off_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            dp_q        <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scoreboard.sv
// Directed bench for seven_seg_scoreboard: small divider instance for digit content and blink,
// larger divider instance for hold length and single-anode checks.
module tb_seven_seg_scoreboard;

    localparam int DIV  = 4;
    localparam int BF   = 2;
    localparam int DIV2 = 1000;

    logic       clk;
    logic       reset;
    logic [4:0] count;
    logic [6:0] score;
    logic [6:0] seg, seg2;
    logic [3:0] an, an2;
    logic       dp, dp2;

    int n_pass;
    int n_checks;

    seven_seg_scoreboard #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .count(count), .score(score),
        .seg(seg), .an(an), .dp(dp)
    );

    seven_seg_scoreboard #(.REFRESH_DIV(DIV2), .BLINK_FRAMES(BF)) dut_long (
        .clk(clk), .reset(reset), .count(count), .score(score),
        .seg(seg2), .an(an2), .dp(dp2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    // Checks the reset hold and the first frame with count=20, score=7; state must be just after a reset edge.
    task automatic check_startup(input string tag);
        logic [11:0] exp_v;
        for (int i = 0; i < DIV; i++) begin
            exp_v = {4'b1111, 7'b1111111, 1'b1};
            n_checks++;
            if ({an, seg, dp} !== exp_v) $display("FAIL %s_rst_hold%0d got=%b exp=%b", tag, i, {an, seg, dp}, exp_v);
            else n_pass++;
            step(1);
        end
        for (int i = 0; i < DIV; i++) begin
            exp_v = {4'b1110, 7'b1111000, 1'b1};
            n_checks++;
            if ({an, seg, dp} !== exp_v) $display("FAIL %s_dig0_hold%0d got=%b exp=%b", tag, i, {an, seg, dp}, exp_v);
            else n_pass++;
            step(1);
        end
        exp_v = {4'b1101, 7'b1111111, 1'b1};
        n_checks++;
        if ({an, seg, dp} !== exp_v) $display("FAIL %s_dig1 got=%b exp=%b", tag, {an, seg, dp}, exp_v);
        else n_pass++;
        step(DIV);
        exp_v = {4'b1011, 7'b1000000, 1'b0};
        n_checks++;
        if ({an, seg, dp} !== exp_v) $display("FAIL %s_dig2 got=%b exp=%b", tag, {an, seg, dp}, exp_v);
        else n_pass++;
        step(DIV);
        exp_v = {4'b0111, 7'b0100100, 1'b1};
        n_checks++;
        if ({an, seg, dp} !== exp_v) $display("FAIL %s_dig3 got=%b exp=%b", tag, {an, seg, dp}, exp_v);
        else n_pass++;
    endtask

    task automatic test_reset();
        count = 5'd20;
        score = 7'd7;
        do_reset();
        check_startup("reset");
    endtask

    // Entered at the last digit of a frame; new inputs are taken at the next capture.
    task automatic test_clamp();
        logic [11:0] exp_v [4];
        exp_v[0] = {4'b1110, 7'b0010000, 1'b1};
        exp_v[1] = {4'b1101, 7'b0010000, 1'b1};
        exp_v[2] = {4'b1011, 7'b0010000, 1'b0};
        exp_v[3] = {4'b0111, 7'b1111111, 1'b1};
        count = 5'd9;
        score = 7'd127;
        for (int d = 0; d < 4; d++) begin
            step(DIV);
            n_checks++;
            if ({an, seg, dp} !== exp_v[d]) $display("FAIL clamp_dig%0d got=%b exp=%b", d, {an, seg, dp}, exp_v[d]);
            else n_pass++;
        end
    endtask

    task automatic test_snapshot();
        logic [11:0] exp_v;
        count = 5'd15;
        step(DIV);
        step(DIV);
        count = 5'd3;
        step(DIV);
        exp_v = {4'b1011, 7'b0010010, 1'b0};
        n_checks++;
        if ({an, seg, dp} !== exp_v) $display("FAIL snap_old_ones got=%b exp=%b", {an, seg, dp}, exp_v);
        else n_pass++;
        step(DIV);
        exp_v = {4'b0111, 7'b1111001, 1'b1};
        n_checks++;
        if ({an, seg, dp} !== exp_v) $display("FAIL snap_old_tens got=%b exp=%b", {an, seg, dp}, exp_v);
        else n_pass++;
        step(3 * DIV);
        exp_v = {4'b1011, 7'b0110000, 1'b0};
        n_checks++;
        if ({an, seg, dp} !== exp_v) $display("FAIL snap_new_ones got=%b exp=%b", {an, seg, dp}, exp_v);
        else n_pass++;
        step(DIV);
        exp_v = {4'b0111, 7'b1111111, 1'b1};
        n_checks++;
        if ({an, seg, dp} !== exp_v) $display("FAIL snap_new_tens got=%b exp=%b", {an, seg, dp}, exp_v);
        else n_pass++;
    endtask

    // Frames 2 and 3 after reset are the first blank phase with BLINK_FRAMES=2.
    task automatic test_blink();
        logic [11:0] exp_v;
        logic        off;
        count = 5'd0;
        score = 7'd42;
        do_reset();
        step(DIV);
        for (int f = 0; f < 6; f++) begin
            off = (f == 2) || (f == 3);
            exp_v = {4'b1110, 7'b0100100, 1'b1};
            n_checks++;
            if ({an, seg, dp} !== exp_v) $display("FAIL blink_f%0d_s_ones got=%b exp=%b", f, {an, seg, dp}, exp_v);
            else n_pass++;
            step(DIV);
            exp_v = {4'b1101, 7'b0011001, 1'b1};
            n_checks++;
            if ({an, seg, dp} !== exp_v) $display("FAIL blink_f%0d_s_tens got=%b exp=%b", f, {an, seg, dp}, exp_v);
            else n_pass++;
            step(DIV);
            exp_v = off ? {4'b1011, 7'b1111111, 1'b1} : {4'b1011, 7'b1000000, 1'b0};
            n_checks++;
            if ({an, seg, dp} !== exp_v) $display("FAIL blink_f%0d_t_ones got=%b exp=%b", f, {an, seg, dp}, exp_v);
            else n_pass++;
            step(DIV);
            exp_v = {4'b0111, 7'b1111111, 1'b1};
            n_checks++;
            if ({an, seg, dp} !== exp_v) $display("FAIL blink_f%0d_t_tens got=%b exp=%b", f, {an, seg, dp}, exp_v);
            else n_pass++;
            step(DIV);
        end
    endtask

    task automatic test_reset_mid();
        count = 5'd20;
        score = 7'd7;
        step(2 * DIV);
        n_checks++;
        if (an !== 4'b1011) $display("FAIL midrst_pre_an got=%b exp=%b", an, 4'b1011);
        else n_pass++;
        do_reset();
        check_startup("midrst");
    endtask

    task automatic test_long_divider();
        int k;
        logic [3:0] prev;
        do_reset();
        k = 0;
        while (an2 === 4'b1111 && k <= 2 * DIV2) begin
            step(1);
            k++;
        end
        n_checks++;
        if (k !== DIV2) $display("FAIL long_first_lit got=%0d exp=%0d", k, DIV2);
        else n_pass++;
        for (int d = 0; d < 6; d++) begin
            n_checks++;
            if ($countones(~an2) !== 1) $display("FAIL long_onehot%0d got=%b exp=one_low", d, an2);
            else n_pass++;
            prev = an2;
            k = 0;
            while (an2 === prev && k <= 2 * DIV2) begin
                step(1);
                k++;
            end
            n_checks++;
            if (k !== DIV2) $display("FAIL long_hold%0d got=%0d exp=%0d", d, k, DIV2);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass   = 0;
        n_checks = 0;
        reset    = 1'b1;
        count    = 5'd0;
        score    = 7'd0;
        step(2);
        test_reset();
        test_clamp();
        test_snapshot();
        test_blink();
        test_reset_mid();
        test_long_divider();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
